seq_serializer: RTL and testbench



---
 rtl/seq_serializer.sv | 124 ++++++++++++
 tb/tb_seq_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// seq_serializer
//   Parallel-to-serial converter feeding the bit-serial sequence detector.
//   Accepts WIDTH-bit words over a valid/ready handshake and emits them one
//   bit per clock, qualified by out_valid. The consumer can stall the stream
//   with out_en. A new word can be loaded on the last-bit cycle of the current
//   one, so consecutive words stream with no idle cycle between them.
//
// Parameters:
//   WIDTH      bits per input word (2..32)
//   MSB_FIRST  1: in_data[WIDTH-1] is sent first; 0: in_data[0] is sent first
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_data    parallel word to serialize
//   in_valid   in_data is valid
//   in_ready   serializer can take a word this cycle (combinational)
//   out_en     consumer takes the current bit this cycle; 0 stalls
//   data_out   current serial bit
//   out_valid  data_out is valid
//   last_bit   data_out is the final bit of the current word
module seq_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_en,
  output logic             data_out,
  output logic             out_valid,
  output logic             last_bit
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg_shifted;
  logic             at_last;
  logic             accept;

  assign at_last = (cnt == CNT_LAST);

  // Shift toward the output end with zero fill.
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg[WIDTH-1:1]};

  // Ready in IDLE, or on the cycle the last bit of the current word is taken,
  // which lets the next word follow without a bubble.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    in_ready = 1'b1;
        SHIFT:   in_ready = out_en & at_last;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    if (accept) begin
      shreg_nxt = in_data;
      cnt_nxt   = '0;
      state_nxt = SHIFT;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = IDLE;
        end
        SHIFT: begin
          if (out_en) begin
            if (at_last) begin
              // Last bit taken with no follow-on word; shreg keeps its
              // contents so data_out holds its last value while idle.
              state_nxt = IDLE;
            end else begin
              shreg_nxt = shreg_shifted;
              cnt_nxt   = cnt + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    out_valid = (state == SHIFT);
    data_out  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    last_bit  = (state == SHIFT) & at_last;
  end

endmodule

// File: tb/tb_seq_serializer.sv
module tb_seq_serializer;

  logic       clk;
  logic       rst;
  logic [5:0] din_a;
  logic [7:0] din_b;
  logic [7:0] din_c;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic       out_en    [3];
  logic       data_out  [3];
  logic       out_valid [3];
  logic       last_bit  [3];

  int checks = 0;
  int errors = 0;

  // u=0: WIDTH=6 MSB first; u=1: WIDTH=8 MSB first; u=2: WIDTH=8 LSB first
  seq_serializer #(.WIDTH(6), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_data(din_a), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_en(out_en[0]), .data_out(data_out[0]),
    .out_valid(out_valid[0]), .last_bit(last_bit[0])
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_data(din_b), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_en(out_en[1]), .data_out(data_out[1]),
    .out_valid(out_valid[1]), .last_bit(last_bit[1])
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst), .in_data(din_c), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_en(out_en[2]), .data_out(data_out[2]),
    .out_valid(out_valid[2]), .last_bit(last_bit[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Inputs are already set; let them settle, check this cycle, then advance.
  task automatic cyc(input int u, input logic ev, input logic ed,
                     input logic el, input logic er, input string tag);
    #1;
    chk({tag, ".valid"}, out_valid[u], ev);
    if (ev) chk({tag, ".data"}, data_out[u], ed);
    chk({tag, ".last"}, last_bit[u], el);
    chk({tag, ".ready"}, in_ready[u], er);
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  exp6;
  logic [11:0] exp12;
  logic [10:0] en11;
  logic [10:0] dat11;
  logic [7:0]  exp8;
  logic [15:0] exp16;

  initial begin
    rst   = 1'b1;
    din_a = '0;
    din_b = '0;
    din_c = '0;
    for (int u = 0; u < 3; u++) begin
      in_valid[u] = 1'b0;
      out_en[u]   = 1'b0;
    end

    // Reset state
    @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst%0d.valid", u), out_valid[u], 1'b0);
      chk($sformatf("rst%0d.data", u), data_out[u], 1'b0);
      chk($sformatf("rst%0d.last", u), last_bit[u], 1'b0);
      chk($sformatf("rst%0d.ready", u), in_ready[u], 1'b0);
    end
    rst = 1'b0;
    #1;
    for (int u = 0; u < 3; u++)
      chk($sformatf("idle%0d.ready", u), in_ready[u], 1'b1);
    @(posedge clk);
    #1;

    // Single word, WIDTH=6, MSB first
    din_a       = 6'b101101;
    in_valid[0] = 1'b1;
    out_en[0]   = 1'b1;
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, "t1.acc");
    in_valid[0] = 1'b0;
    exp6 = 6'b101101;
    for (int i = 0; i < 6; i++)
      cyc(0, 1'b1, exp6[5-i], (i == 5), (i == 5), $sformatf("t1.b%0d", i));
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, "t1.done");

    // Back-to-back words, boundary-spanning pattern unbroken
    din_a       = 6'b111101;
    in_valid[0] = 1'b1;
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, "t2.acc");
    din_a = 6'b101000;
    exp12 = 12'b111101101000;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) in_valid[0] = 1'b0;
      cyc(0, 1'b1, exp12[11-i], (i == 5 || i == 11), (i == 5 || i == 11),
          $sformatf("t2.b%0d", i));
    end
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, "t2.done");

    // Stall for 3 cycles while the 3rd bit of 8'hA5 is presented
    din_b       = 8'hA5;
    in_valid[1] = 1'b1;
    out_en[1]   = 1'b1;
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, "t3.acc");
    in_valid[1] = 1'b0;
    en11  = 11'b11000111111;
    dat11 = 11'b10111100101;
    for (int i = 0; i < 11; i++) begin
      out_en[1] = en11[10-i];
      cyc(1, 1'b1, dat11[10-i], (i == 10), (i == 10), $sformatf("t3.b%0d", i));
    end
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, "t3.done");

    // LSB first, 8'h0D
    din_c       = 8'h0D;
    in_valid[2] = 1'b1;
    out_en[2]   = 1'b1;
    cyc(2, 1'b0, 1'b0, 1'b0, 1'b1, "t4.acc");
    in_valid[2] = 1'b0;
    exp8 = 8'b10110000;
    for (int i = 0; i < 8; i++)
      cyc(2, 1'b1, exp8[7-i], (i == 7), (i == 7), $sformatf("t4.b%0d", i));
    cyc(2, 1'b0, 1'b0, 1'b0, 1'b1, "t4.done");

    // Reset after the 4th bit of 8'hFF, then a clean 8'h81
    din_b       = 8'hFF;
    in_valid[1] = 1'b1;
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, "t5.acc");
    in_valid[1] = 1'b0;
    for (int i = 0; i < 4; i++)
      cyc(1, 1'b1, 1'b1, 1'b0, 1'b0, $sformatf("t5.b%0d", i));
    rst = 1'b1;
    #1;
    chk("t5.rst.ready", in_ready[1], 1'b0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    din_b       = 8'h81;
    in_valid[1] = 1'b1;
    #1;
    chk("t5.post.valid", out_valid[1], 1'b0);
    chk("t5.post.data", data_out[1], 1'b0);
    chk("t5.post.last", last_bit[1], 1'b0);
    chk("t5.post.ready", in_ready[1], 1'b1);
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    exp8 = 8'b10000001;
    for (int i = 0; i < 8; i++)
      cyc(1, 1'b1, exp8[7-i], (i == 7), (i == 7), $sformatf("t5.w%0d", i));
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, "t5.done");

    // Busy backpressure: 8'h3C waits behind 8'hC3
    din_b       = 8'hC3;
    in_valid[1] = 1'b1;
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, "t6.acc");
    din_b = 8'h3C;
    exp16 = 16'hC33C;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) in_valid[1] = 1'b0;
      cyc(1, 1'b1, exp16[15-i], (i == 7 || i == 15), (i == 7 || i == 15),
          $sformatf("t6.b%0d", i));
    end
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, "t6.done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
